// File: rtl/alu_op_pkg.sv
// ALU operation codes and execution FSM state encoding,
// shared by ALU control, the execution unit and the testbench.
package alu_op_pkg;

    localparam logic [3:0] OP_AND      = 4'b0000;
    localparam logic [3:0] OP_OR       = 4'b0001;
    localparam logic [3:0] OP_NOR      = 4'b0010;
    localparam logic [3:0] OP_ADD      = 4'b0011;
    localparam logic [3:0] OP_SUB      = 4'b0100;
    localparam logic [3:0] OP_DEFAULT  = 4'b1001;
    localparam logic [3:0] OP_MULTPLUS = 4'b1010;
    localparam logic [3:0] OP_MOV      = 4'b1011;
    localparam logic [3:0] OP_INC      = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_MADD = 2'd3
    } alu_state_e;

    function automatic logic is_mult(input logic [3:0] op);
        return op == OP_MULTPLUS;
    endfunction

endpackage

// File: rtl/alu_shift_add_mult.sv
// Iterative shift-add multiplier datapath: one partial product per step,
// keeping only the low WIDTH bits of the product.
module alu_shift_add_mult #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             last_o
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    assign last_o = (cnt_q == CNT_W'(WIDTH - 1));
    assign acc_o  = acc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            cnt_q    <= '0;
        end else if (step_i) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            // Saturate on the final step; the FSM leaves MUL there.
            if (!last_o) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Execution unit: single-cycle logic/arith ops and a multi-cycle
// MULTPLUS (A*B+A), sequenced by a start/busy/done handshake.
module multicycle_alu
    import alu_op_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUOperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    alu_state_e       state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             busy_q, done_q, zero_q;
    logic [WIDTH-1:0] res_q;

    logic [WIDTH-1:0] exec_res_d;
    logic [WIDTH-1:0] madd_res_d;
    logic [WIDTH-1:0] acc;
    logic             accept, mul_load, mul_step, mul_last;

    // The done cycle is still part of the transaction, so no new accept.
    assign accept   = start && (state_q == ST_IDLE) && !done_q;
    assign mul_load = accept && is_mult(ALUOperation);
    assign mul_step = (state_q == ST_MUL);

    alu_shift_add_mult #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mult (
        .clk    (clk),
        .reset  (reset),
        .load_i (mul_load),
        .step_i (mul_step),
        .a_i    (A),
        .b_i    (B),
        .acc_o  (acc),
        .last_o (mul_last)
    );

    always_comb begin
        exec_res_d = '0;
        unique case (op_q)
            OP_AND:  exec_res_d = a_q & b_q;
            OP_OR:   exec_res_d = a_q | b_q;
            OP_NOR:  exec_res_d = ~(a_q | b_q);
            OP_ADD:  exec_res_d = a_q + b_q;
            OP_SUB:  exec_res_d = a_q - b_q;
            OP_INC:  exec_res_d = a_q + WIDTH'(1);
            OP_MOV:  exec_res_d = b_q;
            default: exec_res_d = '0;
        endcase
    end

    assign madd_res_d = acc + a_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= ALUOperation;
                        a_q     <= A;
                        b_q     <= B;
                        busy_q  <= 1'b1;
                        state_q <= is_mult(ALUOperation) ? ST_MUL : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_q   <= exec_res_d;
                    zero_q  <= (exec_res_d == '0);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_MUL: begin
                    if (mul_last) begin
                        state_q <= ST_MADD;
                    end
                end
                ST_MADD: begin
                    res_q   <= madd_res_d;
                    zero_q  <= (madd_res_d == '0);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ALUResult = res_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed corner cases plus
// randomized ops against an arithmetic reference model.
module tb_multicycle_alu;
    import alu_op_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, zero;
    logic [W-1:0] res;

    int checks   = 0;
    int failures = 0;

    multicycle_alu #(.WIDTH(W), .CNT_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ALUOperation (op),
        .A            (a),
        .B            (b),
        .busy         (busy),
        .done         (done),
        .ALUResult    (res),
        .Zero         (zero)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [3:0] o,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        logic [63:0] p;
        case (o)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return ~(x | y);
            4'b0011: return W'((64'(x) + 64'(y)) % 64'h1_0000_0000);
            4'b0100: return W'((64'(x) + 64'h1_0000_0000 - 64'(y)) % 64'h1_0000_0000);
            4'b1111: return W'((64'(x) + 64'd1) % 64'h1_0000_0000);
            4'b1011: return y;
            4'b1010: begin
                p = 64'(x) * 64'(y) + 64'(x);
                return p[W-1:0];
            end
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] e;
        int lat, n;
        e   = model(o, x, y);
        lat = (o == 4'b1010) ? W + 1 : 1;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 100) begin
            a  = $urandom;
            b  = $urandom;
            op = 4'($urandom);
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_res"}, 64'(res), 64'(e));
        chk({tag, "_zero"}, 64'(zero), 64'(e == '0));
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(done), 64'd0);
        chk({tag, "_hold"}, 64'(res), 64'(e));
    endtask

    initial begin
        logic [3:0] ops [10];
        int n, cnt;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                4'b1111, 4'b1011, 4'b1010, 4'b0111, 4'b1001};

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);
        reset = 1'b0;

        run_op("add_wrap", 4'b0011, 32'hFFFF_FFFF, 32'd1);
        run_op("sub_eq", 4'b0100, 32'd5, 32'd5);
        run_op("nor0", 4'b0010, 32'd0, 32'd0);
        run_op("mov", 4'b1011, 32'hDEAD_BEEF, 32'h1234);
        run_op("mult_3_7", 4'b1010, 32'd3, 32'd7);
        run_op("mult_hi", 4'b1010, 32'h1_0000, 32'h1_0000);
        run_op("undef", 4'b0111, 32'd9, 32'd9);
        run_op("inc", 4'b1111, 32'h7FFF_FFFF, 32'h0);

        // Leave a nonzero result, then reset in the middle of a multiply.
        run_op("mov2", 4'b1011, 32'h0, 32'h55);
        @(negedge clk);
        start = 1'b1; op = 4'b1010; a = 32'd3; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        chk("mrst_res", 64'(res), 64'd0);
        chk("mrst_zero", 64'(zero), 64'd1);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("mrst_nodone", 64'(cnt), 64'd0);

        // start held through a multiply and its done cycle.
        @(negedge clk);
        start = 1'b1; op = 4'b1010; a = 32'd3; b = 32'd7;
        @(negedge clk);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hold_lat", 64'(n), 64'(W + 1));
        chk("hold_res", 64'(res), 64'd24);
        op = 4'b0011; a = 32'd1; b = 32'd2;
        @(negedge clk);
        chk("hold_noacc", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        chk("hold_acc", 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hold_add_lat", 64'(n), 64'd1);
        chk("hold_add_res", 64'(res), 64'd3);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("hold_one_extra", 64'(cnt), 64'd0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] x, y;
            x = $urandom;
            y = $urandom;
            if (i % 4 == 0) y = x;
            if (i % 5 == 0) x = W'($urandom_range(0, 15));
            run_op("rand", ops[$urandom_range(0, 9)], x, y);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
